// File: rtl/sdcard_bus_arbiter.sv
// sdcard_bus_arbiter
//   Shares the SD card CMD/DAT bus among three requesters (bit0 = command
//   engine, bit1 = data engine, bit2 = maintenance). Round-robin, registered
//   one-hot grants, one turnaround cycle between owners, per-grant timeout,
//   security gating and power-down gating.
//
// Ports
//   PCLK_i            clock
//   PRESETn_i         asynchronous active-low reset
//   req_i[2:0]        level requests
//   done_i[2:0]       one-cycle release pulse from the current owner
//   access_granted_i  0 blocks every new grant (requests are denied instead)
//   power_state_i     2'b11 = power-down request
//   timeout_limit_i   max grant length in cycles, 0 = no timeout
//   gnt_o[2:0]        one-hot grant
//   owner_o           index of the current or last owner
//   busy_o            a grant is active
//   deny_o[2:0]       per-requester security-deny pulse
//   timeout_o         one-cycle pulse on forced release
//   timeout_cnt_o     saturating count of forced releases
//   pwrdn_o           arbiter is parked in power-down
module sdcard_bus_arbiter #(
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 PCLK_i,
    input  logic                 PRESETn_i,
    input  logic [2:0]           req_i,
    input  logic [2:0]           done_i,
    input  logic                 access_granted_i,
    input  logic [1:0]           power_state_i,
    input  logic [TIMEOUT_W-1:0] timeout_limit_i,
    output logic [2:0]           gnt_o,
    output logic [1:0]           owner_o,
    output logic                 busy_o,
    output logic [2:0]           deny_o,
    output logic                 timeout_o,
    output logic [CNT_W-1:0]     timeout_cnt_o,
    output logic                 pwrdn_o
);

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2,
        ARB_PWRDN   = 2'd3
    } arb_state_t;

    arb_state_t state_q, state_d;

    logic [1:0]           last_q, last_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       gnt_d;
    logic [1:0]       owner_d;
    logic             busy_d;
    logic [2:0]       deny_d;
    logic             timeout_d;
    logic [CNT_W-1:0] tcnt_d;
    logic             pwrdn_d;

    logic       pwr_req;
    logic       any_req;
    logic [1:0] pick;
    logic       own_done;
    logic       own_req;
    logic       to_hit;
    logic       release_now;
    logic       timeout_fire;

    assign pwr_req = (power_state_i == 2'b11);
    assign any_req = |req_i;

    // The registered grant vector doubles as the owner mask, so the owner's
    // done/req bits are selected without indexing by owner_o.
    assign own_done = |(done_i & gnt_o);
    assign own_req  = |(req_i & gnt_o);
    assign to_hit   = (timeout_limit_i != '0) &&
                      (cnt_q == timeout_limit_i - TIMEOUT_W'(1));

    // done and abandon both take priority over the timeout: a voluntary
    // release never counts as a forced one.
    assign release_now  = own_done | ~own_req | to_hit;
    assign timeout_fire = to_hit & ~own_done & own_req;

    // Round-robin: search upward from the requester after the last owner.
    always_comb begin
        pick = 2'd0;
        case (last_q)
            2'd0:    pick = req_i[1] ? 2'd1 : (req_i[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req_i[2] ? 2'd2 : (req_i[0] ? 2'd0 : 2'd1);
            default: pick = req_i[0] ? 2'd0 : (req_i[1] ? 2'd1 : 2'd2);
        endcase
    end

    // State register
    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) state_q <= ARB_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (pwr_req)                            state_d = ARB_PWRDN;
                else if (any_req && access_granted_i)   state_d = ARB_GRANT;
            end
            ARB_GRANT:   if (release_now) state_d = ARB_RELEASE;
            ARB_RELEASE: state_d = ARB_IDLE;
            ARB_PWRDN:   if (!pwr_req) state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and datapath.
    always_comb begin
        gnt_d     = gnt_o;
        owner_d   = owner_o;
        last_d    = last_q;
        cnt_d     = cnt_q;
        deny_d    = 3'b000;
        timeout_d = 1'b0;
        tcnt_d    = timeout_cnt_o;
        case (state_q)
            ARB_IDLE: begin
                if (!pwr_req && any_req) begin
                    if (!access_granted_i) begin
                        deny_d = req_i;
                    end else begin
                        gnt_d   = 3'b001 << pick;
                        owner_d = pick;
                        last_d  = pick;
                        cnt_d   = '0;
                    end
                end
            end
            ARB_GRANT: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (release_now) gnt_d = 3'b000;
                if (timeout_fire) begin
                    timeout_d = 1'b1;
                    if (timeout_cnt_o != {CNT_W{1'b1}})
                        tcnt_d = timeout_cnt_o + CNT_W'(1);
                end
            end
            default: gnt_d = 3'b000;
        endcase
        busy_d  = (state_d == ARB_GRANT);
        pwrdn_d = (state_d == ARB_PWRDN);
    end

    // Output and datapath registers
    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            gnt_o         <= 3'b000;
            owner_o       <= 2'd0;
            busy_o        <= 1'b0;
            deny_o        <= 3'b000;
            timeout_o     <= 1'b0;
            timeout_cnt_o <= '0;
            pwrdn_o       <= 1'b0;
            last_q        <= 2'd2;
            cnt_q         <= '0;
        end else begin
            gnt_o         <= gnt_d;
            owner_o       <= owner_d;
            busy_o        <= busy_d;
            deny_o        <= deny_d;
            timeout_o     <= timeout_d;
            timeout_cnt_o <= tcnt_d;
            pwrdn_o       <= pwrdn_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: doc/sdcard_bus_arbiter.md
# sdcard_bus_arbiter

Shares the SD card physical bus (CMD/DAT lines) among three requesters: command engine, data engine and maintenance/housekeeping logic. Sits between those engines and the SD interface block; issues one-hot, registered grants with round-robin fairness, a turnaround cycle between owners, a per-grant timeout, security gating and power-down gating.

## Interface
- TIMEOUT_W, 16, width of grant timeout counter and limit
- CNT_W, 8, width of saturating timeout statistics counter
- PCLK_i  in  1  clock
- PRESETn_i  in  1  reset, asynchronous, active-low
- req_i  in  3  level requests; bit0 = cmd, bit1 = data, bit2 = maintenance
- done_i  in  3  one-cycle release pulse from the current owner
- access_granted_i  in  1  security permission; 0 blocks all new grants
- power_state_i  in  2  2'b11 = power-down; other values = active
- timeout_limit_i  in  TIMEOUT_W  max grant length in cycles; 0 disables the timeout
- gnt_o  out  3  one-hot grant (at most one bit set)
- owner_o  out  2  index of the current or last owner
- busy_o  out  1  high while any grant is active
- deny_o  out  3  per-requester security-deny pulse
- timeout_o  out  1  one-cycle pulse on forced release
- timeout_cnt_o  out  CNT_W  saturating count of timeouts
- pwrdn_o  out  1  high in power-down state

## Operation
- States: ARB_IDLE, ARB_GRANT, ARB_RELEASE, ARB_PWRDN. Reset state ARB_IDLE.
- ARB_IDLE:
  - If power_state_i == 2'b11: go to ARB_PWRDN. Power-down takes precedence over requests.
  - Else if req_i != 0 and access_granted_i == 0: stay in ARB_IDLE; deny_o <= req_i for one cycle. deny_o re-pulses every cycle the condition holds.
  - Else if req_i != 0: pick the first set bit, searching from (last_owner+1) mod 3 upward with wrap. Then gnt_o <= onehot(pick), owner_o <= pick, last_owner <= pick, counter cleared, go to ARB_GRANT.
- ARB_GRANT: the owner keeps the bus; the arbiter never preempts. Release happens on the first of these:
  - done_i[owner] = 1
  - req_i[owner] = 0 (abandon)
  - timeout: timeout_limit_i != 0 and counter == timeout_limit_i - 1. This also pulses timeout_o and increments timeout_cnt_o, saturating at all-ones.
  - On release: gnt_o <= 0, go to ARB_RELEASE.
  - done_i and timeout in the same cycle: done wins; no timeout_o, no count.
  - done_i bits of non-owners are ignored.
  - A power-down request is honoured only after the current owner releases.
- ARB_RELEASE: exactly one cycle with no grant (bus turnaround), then ARB_IDLE.
- ARB_PWRDN: pwrdn_o = 1, no grants, deny_o = 0. Return to ARB_IDLE when power_state_i != 2'b11.
- Counter: TIMEOUT_W bits, increments each ARB_GRANT cycle, no wrap needed because the timeout fires first. When timeout_limit_i = 0 the counter may wrap harmlessly.
- busy_o = (state == ARB_GRANT), registered alongside gnt_o.
- last_owner resets to 2, so the first grant after reset prefers cmd.

## Timing
- Reset values: gnt_o = 0, owner_o = 0, busy_o = 0, deny_o = 0, timeout_o = 0, timeout_cnt_o = 0, pwrdn_o = 0. Assertion of PRESETn_i mid-grant drops gnt_o immediately (asynchronously).
- Request latency: request sampled at edge N in ARB_IDLE; gnt_o high after edge N.
- Release latency: done_i sampled at edge K; gnt_o low after K; ARB_RELEASE during K..K+1; ARB_IDLE K+1..K+2; next gnt_o after K+2.
  - Minimum gap between grants is 2 cycles; minimum grant length is 1 cycle.
- Timeout with limit L: gnt_o high exactly L cycles; timeout_o coincides with the first cycle of gnt_o low.
- deny_o, timeout_o: single-cycle, registered.
- Power-down entry from ARB_IDLE: pwrdn_o high one cycle after power_state_i = 2'b11 is sampled. Exit: ARB_IDLE next cycle; a grant is possible one cycle later.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then req_i = 3'b011 held with done pulses: grants alternate cmd, data, cmd, data; each done is followed by exactly 2 no-grant cycles.
- req_i = 3'b111 continuously, done after 3 cycles each: grant order 0, 1, 2, 0; gnt_o is never multi-hot; busy_o matches |gnt_o.
- timeout_limit_i = 5, owner never sends done: gnt_o high 5 cycles, timeout_o pulses once, timeout_cnt_o = 1. Repeat 300 times: count saturates at 255.
- access_granted_i = 0 with req_i = 3'b010: no grant; deny_o = 3'b010 every cycle. Raise access_granted_i: grant to data next cycle.
- power_state_i = 2'b11 during a data grant: grant continues until done, then ARB_RELEASE, then pwrdn_o = 1 and requests are ignored. power_state_i = 2'b00: grant resumes after 2 cycles.
- done_i[0] and timeout in the same cycle: no timeout_o, count unchanged. PRESETn_i low mid-grant: all outputs return to reset values immediately.
